// File: rtl/rc5_key_mix_if.sv
// RC5 key-mix bus: start/busy/done handshake plus the S and L RAM ports.
// master = key-mix engine, slave = RAMs and the controller that pulses start.
interface rc5_key_mix_if #(
  parameter int W = 32,
  parameter int B = 16,
  parameter int R = 12
);
  localparam int U        = W / 8;
  localparam int C        = B / U;
  localparam int T        = 2 * (R + 1);
  localparam int T_LENGTH = $clog2(T);
  localparam int C_LENGTH = $clog2(C);

  logic                start;
  logic [T_LENGTH-1:0] S_address;
  logic [W-1:0]        S_sub_i;
  logic [W-1:0]        S_sub_i_prima;
  logic                S_we;
  logic [C_LENGTH-1:0] L_address;
  logic [W-1:0]        L_sub_i;
  logic [W-1:0]        L_sub_i_prima;
  logic                L_we;
  logic                busy;
  logic                done;

  modport master (
    input  start, S_sub_i, L_sub_i,
    output S_address, S_sub_i_prima, S_we,
           L_address, L_sub_i_prima, L_we,
           busy, done
  );

  modport slave (
    output start, S_sub_i, L_sub_i,
    input  S_address, S_sub_i_prima, S_we,
           L_address, L_sub_i_prima, L_we,
           busy, done
  );
endinterface

// File: rtl/rc5_key_mix.sv
// RC5 key-schedule mixing stage. Runs N = 3*max(T,C) iterations of
//   A = S[i] = rotl(S[i]+A+B, 3);  B = L[j] = rotl(L[j]+A+B, A+B)
// over external S (T words) and L (C words) RAMs with 1-cycle read latency.
// Each iteration is 4 cycles: ADDR, READ, MIX_S (S write), MIX_L (L write).
// Optional macro RC5_S_INIT_EN: an INIT phase first fills S[i] = P + i*Q,
// one word per cycle; without it S must be preloaded before start.
module rc5_key_mix #(
  parameter int W = 32,
  parameter int B = 16,
  parameter int R = 12
) (
  input logic           clk,
  input logic           rst,
  rc5_key_mix_if.master bus
);
  localparam int U        = W / 8;
  localparam int C        = B / U;
  localparam int T        = 2 * (R + 1);
  localparam int N        = 3 * ((T > C) ? T : C);
  localparam int T_LENGTH = $clog2(T);
  localparam int C_LENGTH = $clog2(C);
  localparam int CNT_W    = $clog2(N);
  localparam int SH_W     = $clog2(W);

`ifdef RC5_S_INIT_EN
  localparam logic [W-1:0] P = (W == 16) ? W'(64'hB7E1) :
                               (W == 32) ? W'(64'hB7E15163) :
                                           W'(64'hB7E151628AED2A6B);
  localparam logic [W-1:0] Q = (W == 16) ? W'(64'h9E37) :
                               (W == 32) ? W'(64'h9E3779B9) :
                                           W'(64'h9E3779B97F4A7C15);
`endif

  typedef enum logic [2:0] {
    IDLE,
`ifdef RC5_S_INIT_EN
    INIT,
`endif
    ADDR,
    READ,
    MIX_S,
    MIX_L,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     l_q;
  logic [CNT_W-1:0] count_q;

  logic [W-1:0] sum_s;
  logic [W-1:0] a_next;
  logic [W-1:0] ab_sum;
  logic [W-1:0] sum_l;
  logic [W-1:0] b_next;

  // Rotate left: the upper half of {x,x} shifted by n is x rotated by n,
  // and n = 0 falls out naturally.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                        input logic [SH_W-1:0] n);
    logic [2*W-1:0] d;
    d = {x, x} << n;
    return d[2*W-1:W];
  endfunction

  // S-side mix uses the RAM word as it arrives in READ.
  assign sum_s  = bus.S_sub_i + a_q + b_q;
  assign a_next = rotl(sum_s, SH_W'(3));
  // L-side mix runs in MIX_S, when a_q already holds the new A.
  assign ab_sum = a_q + b_q;
  assign sum_l  = l_q + ab_sum;
  assign b_next = rotl(sum_l, ab_sum[SH_W-1:0]);

  // Sequencer and all registered outputs. S_address/L_address double as i/j.
  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // a blocking A update would leak the new A into same-edge expressions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      a_q               <= '0;
      b_q               <= '0;
      l_q               <= '0;
      count_q           <= '0;
      bus.S_address     <= '0;
      bus.S_sub_i_prima <= '0;
      bus.S_we          <= 1'b0;
      bus.L_address     <= '0;
      bus.L_sub_i_prima <= '0;
      bus.L_we          <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q           <= '0;
            b_q           <= '0;
            count_q       <= '0;
            bus.S_address <= '0;
            bus.L_address <= '0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
`ifdef RC5_S_INIT_EN
            bus.S_sub_i_prima <= P;
            bus.S_we          <= 1'b1;
            state             <= INIT;
`else
            state             <= ADDR;
`endif
          end
        end
`ifdef RC5_S_INIT_EN
        INIT: begin
          if (bus.S_address == T_LENGTH'(T - 1)) begin
            bus.S_we      <= 1'b0;
            bus.S_address <= '0;
            state         <= ADDR;
          end else begin
            bus.S_address     <= bus.S_address + 1'b1;
            bus.S_sub_i_prima <= bus.S_sub_i_prima + Q;
          end
        end
`endif
        ADDR: state <= READ;
        READ: begin
          a_q               <= a_next;
          bus.S_sub_i_prima <= a_next;
          bus.S_we          <= 1'b1;
          l_q               <= bus.L_sub_i;
          state             <= MIX_S;
        end
        MIX_S: begin
          bus.S_we          <= 1'b0;
          b_q               <= b_next;
          bus.L_sub_i_prima <= b_next;
          bus.L_we          <= 1'b1;
          state             <= MIX_L;
        end
        MIX_L: begin
          bus.L_we <= 1'b0;
          if (count_q == CNT_W'(N - 1)) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            count_q       <= count_q + 1'b1;
            // T is not a power of two, so i wraps on an explicit compare.
            bus.S_address <= (bus.S_address == T_LENGTH'(T - 1)) ? '0 : bus.S_address + 1'b1;
            bus.L_address <= (bus.L_address == C_LENGTH'(C - 1)) ? '0 : bus.L_address + 1'b1;
            state         <= ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc5_key_mix.sv
// Self-checking bench for rc5_key_mix (W=32, B=16, R=12). Holds the S/L RAMs,
// a plain-arithmetic model of the whole key mix (expected write stream, final
// S/L, busy/done timing) and one per-cycle compare process.
module tb_rc5_key_mix;
  localparam int W  = 32;
  localparam int B  = 16;
  localparam int R  = 12;
  localparam int T  = 2 * (R + 1);
  localparam int C  = B / (W / 8);
  localparam int N  = 3 * ((T > C) ? T : C);
`ifdef RC5_S_INIT_EN
  localparam int INIT_WR = T;
`else
  localparam int INIT_WR = 0;
`endif
  localparam int LAT = INIT_WR + 4 * N;
  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;

  typedef struct {
    bit          is_l;
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  rc5_key_mix_if #(.W(W), .B(B), .R(R)) bus ();
  rc5_key_mix #(.W(W), .B(B), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAMs (1-cycle read latency, bulk preload port) ----------
  logic [31:0] s_mem [T];
  logic [31:0] l_mem [C];
  logic [31:0] pre_s [T];
  logic [31:0] pre_l [C];
  logic        load_req;

  always @(posedge clk) begin
    if (load_req) begin
      s_mem <= pre_s;
      l_mem <= pre_l;
    end else begin
      if (bus.S_we) s_mem[bus.S_address] <= bus.S_sub_i_prima;
      if (bus.L_we) l_mem[bus.L_address] <= bus.L_sub_i_prima;
    end
    bus.S_sub_i <= s_mem[bus.S_address];
    bus.L_sub_i <= l_mem[bus.L_address];
  end

  // ---------------- behavioural model ---------------------------------------
  wr_t         exp_q[$];
  logic [31:0] model_s [T];
  logic [31:0] model_l [C];
  logic [31:0] first_mix_s, first_mix_l, init_s1;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic void build_model();
    logic [31:0] s [T];
    logic [31:0] l [C];
    logic [31:0] a, b;
    int i, j;
    exp_q.delete();
    for (int k = 0; k < T; k++) begin
`ifdef RC5_S_INIT_EN
      s[k] = P + Q * 32'(k);
      exp_q.push_back('{is_l: 1'b0, addr: k, data: s[k]});
`else
      s[k] = s_mem[k];
`endif
    end
    init_s1 = P + Q;
    for (int k = 0; k < C; k++) l[k] = l_mem[k];
    a = '0;
    b = '0;
    for (int k = 0; k < N; k++) begin
      i = k % T;
      j = k % C;
      a = rotl32(s[i] + a + b, 3);
      s[i] = a;
      exp_q.push_back('{is_l: 1'b0, addr: i, data: a});
      b = rotl32(l[j] + a + b, int'((a + b) % 32));
      l[j] = b;
      exp_q.push_back('{is_l: 1'b1, addr: j, data: b});
      if (k == 0) begin
        first_mix_s = a;
        first_mix_l = b;
      end
    end
    model_s = s;
    model_l = l;
  endfunction

  // ---------------- per-cycle compare process -------------------------------
  int  e = 0;
  int  accept_edge = 0;
  int  done_edge_seen = -1;
  int  s_writes = 0;
  int  l_writes = 0;
  int  mix_s_addr [N];
  int  mix_l_addr [N];
  bit  m_busy = 1'b0;
  bit  m_done = 1'b0;
  bit  prev_done = 1'b0;
  bit  cmp_ok;
  wr_t cmp_w;

  always begin
    @(posedge clk);
    #1;
    e++;
    if (!rst) begin
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_we", 64'({bus.S_we, bus.L_we}), 64'd0);
      check("rst_addr", 64'({bus.S_address, bus.L_address}), 64'd0);
      m_busy = 1'b0;
      m_done = 1'b0;
      prev_done = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.start && !m_busy) begin
        accept_edge = e;
        done_edge_seen = -1;
        m_busy = 1'b1;
        m_done = 1'b0;
        s_writes = 0;
        l_writes = 0;
        build_model();
      end
      if (m_busy && e == accept_edge + LAT) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done));
      check("we_exclusive", 64'(bus.S_we & bus.L_we), 64'd0);
      if (bus.S_we) begin
        cmp_ok = exp_q.size() > 0 && !exp_q[0].is_l;
        check("s_write_expected", 64'(cmp_ok), 64'd1);
        if (cmp_ok) begin
          cmp_w = exp_q.pop_front();
          check("s_addr", 64'(bus.S_address), 64'(cmp_w.addr));
          check("s_data", 64'(bus.S_sub_i_prima), 64'(cmp_w.data));
        end
        if (s_writes >= INIT_WR && s_writes - INIT_WR < N)
          mix_s_addr[s_writes - INIT_WR] = int'(bus.S_address);
        s_writes++;
      end
      if (bus.L_we) begin
        cmp_ok = exp_q.size() > 0 && exp_q[0].is_l;
        check("l_write_expected", 64'(cmp_ok), 64'd1);
        if (cmp_ok) begin
          cmp_w = exp_q.pop_front();
          check("l_addr", 64'(bus.L_address), 64'(cmp_w.addr));
          check("l_data", 64'(bus.L_sub_i_prima), 64'(cmp_w.data));
        end
        if (l_writes < N) mix_l_addr[l_writes] = int'(bus.L_address);
        l_writes++;
      end
      if (bus.done && !prev_done) done_edge_seen = e;
      prev_done = bus.done;
    end
  end

  // ---------------- driver --------------------------------------------------
  logic [31:0] first_final [T];

  task automatic load_mem(input bit rand_s, input bit rand_l);
    @(negedge clk);
    for (int i = 0; i < T; i++) pre_s[i] = rand_s ? $urandom : P + Q * 32'(i);
    for (int j = 0; j < C; j++) pre_l[j] = rand_l ? $urandom : 32'd0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_run();
    int c;
    c = 0;
    while (!bus.done && c < LAT + 50) begin
      @(negedge clk);
      c++;
    end
    check("done_reached", 64'(bus.done), 64'd1);
    check("latency", 64'(done_edge_seen - accept_edge), 64'(LAT));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("s_write_count", 64'(s_writes), 64'(N + INIT_WR));
    check("l_write_count", 64'(l_writes), 64'(N));
    for (int i = 0; i < T; i++) check("final_s", 64'(s_mem[i]), 64'(model_s[i]));
    for (int j = 0; j < C; j++) check("final_l", 64'(l_mem[j]), 64'(model_l[j]));
    check("s_wrap_last", 64'(mix_s_addr[T - 1]), 64'(T - 1));
    check("s_wrap_first", 64'(mix_s_addr[T]), 64'd0);
    check("l_wrap_last", 64'(mix_l_addr[C - 1]), 64'(C - 1));
    check("l_wrap_first", 64'(mix_l_addr[C]), 64'd0);
  endtask

  initial begin
    int c;
    rst = 1'b0;
    bus.start = 1'b0;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Run A: S = P + i*Q, L = 0 (the zero key).
    load_mem(1'b0, 1'b0);
    pulse_start();
    check("model_first_s", 64'(first_mix_s), 64'h00000000BF0A8B1D);
    check("model_first_l", 64'(first_mix_l), 64'h00000000B7E15163);
    check("model_init_s1", 64'(init_s1), 64'h000000005618CB1C);
    finish_run();
    first_final = s_mem;

    // Run B: same inputs restarted from DONE, with a stray start mid-run.
    load_mem(1'b0, 1'b0);
    pulse_start();
    repeat (48) @(negedge clk);
    pulse_start();
    finish_run();
    for (int i = 0; i < T; i++) check("repeat_identical", 64'(s_mem[i]), 64'(first_final[i]));

    // Run C: random key (and random S when S is preloaded).
    load_mem(1'b1, 1'b1);
    pulse_start();
    finish_run();

    // Run D: reset dropped during an MIX_S cycle, then a full random run.
    load_mem(1'b1, 1'b1);
    pulse_start();
    c = 0;
    while (e < accept_edge + INIT_WR + 22 && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("pre_reset_s_we", 64'(bus.S_we), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_we", 64'({bus.S_we, bus.L_we}), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load_mem(1'b1, 1'b1);
    pulse_start();
    finish_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
